// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types: FSM states, NOP encoding, prefetch entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, instr, fault}; head read straight from storage flops.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         PW       = $clog2(DEPTH),
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          head_valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop     = pop && (count != '0);
  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: RESET_PC, instr: NOP_INSTR, fault: 1'b0};
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction fetch: credit-limited requests, stale-fetch drop, redirect.
// Optional FETCH_ALIGN_CHECK_EN turns misaligned redirect targets into a fault entry.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [31:0]     ir_instr,
  output logic [XLEN-1:0] ir_pc,
  output logic            ir_fault
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   out_cnt, out_next;
  logic [CW-1:0]   drop_cnt, drop_next;
  logic [CW-1:0]   fifo_count;
  logic            fault_pending;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            fire, pop, keep_rsp, fault_push, push;
  logic [CW:0]     used;
  fetch_entry_t    push_entry, head;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
  assign target     = redirect_pc;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
  localparam bit ALIGN_CHECK = 1'b0;
  assign target     = redirect_pc & ~XLEN'(3);
  assign misaligned = 1'b0;
`endif

  assign fire = imem_req_valid && imem_req_ready;
  assign pop  = ir_valid && ir_ready;

  // A same-cycle pop frees a slot before any new response can land, so it returns credit.
  assign used = {1'b0, out_cnt} + {1'b0, fifo_count} - {CW'(0), pop};

  assign imem_req_valid = reset && (state == ST_RUN) && (drop_cnt == '0) &&
                          (used < (CW+1)'(FIFO_DEPTH)) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;

  always_comb begin
    out_next = out_cnt;
    if (fire)           out_next = out_next + CW'(1);
    if (imem_rsp_valid) out_next = out_next - CW'(1);
    drop_next = drop_cnt;
    if (redirect_valid)                          drop_next = out_next;
    else if (imem_rsp_valid && drop_cnt != '0)   drop_next = drop_cnt - CW'(1);
  end

  assign keep_rsp   = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign fault_push = (state == ST_DRAIN) && !redirect_valid && (drop_next == '0) && fault_pending;
  assign push       = keep_rsp || fault_push;
  assign push_entry = fault_push ? '{pc: 32'(rsp_pc), instr: NOP_INSTR, fault: 1'b1}
                                 : '{pc: 32'(rsp_pc), instr: imem_rsp_data, fault: 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_RUN;
      fetch_pc      <= RESET_PC;
      rsp_pc        <= RESET_PC;
      out_cnt       <= '0;
      drop_cnt      <= '0;
      fault_pending <= 1'b0;
    end else begin
      out_cnt  <= out_next;
      drop_cnt <= drop_next;
      if (redirect_valid) begin
        fetch_pc      <= target;
        rsp_pc        <= target;
        fault_pending <= misaligned;
        // A misaligned target with nothing to drop still passes through DRAIN to emit its fault.
        state         <= (drop_next != '0 || misaligned) ? ST_DRAIN : ST_RUN;
      end else begin
        if (fire)     fetch_pc <= fetch_pc + XLEN'(4);
        if (keep_rsp) rsp_pc   <= rsp_pc + XLEN'(4);
        if (state == ST_DRAIN && drop_next == '0) begin
          state         <= fault_pending ? ST_FAULT : ST_RUN;
          fault_pending <= 1'b0;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .RESET_PC (32'(RESET_PC))
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (ir_valid),
    .count      (fifo_count)
  );

  assign ir_instr = head.instr;
  assign ir_pc    = XLEN'(head.pc);
  assign ir_fault = head.fault && ALIGN_CHECK;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with a fixed-latency memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] ir_instr;
  logic [31:0] ir_pc;
  logic        ir_fault;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_k = 1;
  int t0 = 0;

  typedef struct { logic [31:0] a; int c; } rec_t;
  rec_t        req_log[$];
  rec_t        pend[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  logic        pop_fault[$];
  int          pop_cyc[$];

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_instr       (ir_instr),
    .ir_pc          (ir_pc),
    .ir_fault       (ir_fault)
  );

  always #5 clk = ~clk;

  // Memory returns addr + 0x1000_0000 as the instruction word, mem_k cycles after acceptance.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
    end else if (pend.size() > 0 && pend[0].c <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].a + 32'h1000_0000;
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (imem_req_valid && imem_req_ready) begin
        req_log.push_back('{imem_req_addr, cyc});
        pend.push_back('{imem_req_addr, cyc + mem_k});
      end
      if (ir_valid && ir_ready) begin
        pop_pc.push_back(ir_pc);
        pop_instr.push_back(ir_instr);
        pop_fault.push_back(ir_fault);
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_run(input bit rdy, input int k);
    reset = 1'b0;
    redirect_valid = 1'b0;
    ir_ready = rdy;
    mem_k = k;
    cycles(2);
    req_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    pop_fault.delete();
    pop_cyc.delete();
    reset = 1'b1;
    t0 = cyc;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    cycles(1);
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cycles(2);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h exp 00000000", imem_req_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %b exp 0", ir_valid); end
    checks++; if (ir_instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_ir_instr got %h exp 00000013", ir_instr); end
    checks++; if (ir_pc !== 32'h0) begin errors++; $display("FAIL reset_ir_pc got %h exp 00000000", ir_pc); end
    checks++; if (ir_fault !== 1'b0) begin errors++; $display("FAIL reset_ir_fault got %b exp 0", ir_fault); end
  endtask

  task automatic test_stream;
    start_run(1'b1, 1);
    cycles(8);
    checks++; if (req_log.size() < 3 || pop_pc.size() < 3) begin errors++; $display("FAIL stream_count got req=%0d pop=%0d exp >=3", req_log.size(), pop_pc.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (req_log[i].a !== 32'(4 * i)) begin errors++; $display("FAIL stream_req_addr[%0d] got %h exp %h", i, req_log[i].a, 32'(4 * i)); end
        checks++; if (req_log[i].c - t0 !== i) begin errors++; $display("FAIL stream_req_cycle[%0d] got %0d exp %0d", i, req_log[i].c - t0, i); end
        checks++; if (pop_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_pop_pc[%0d] got %h exp %h", i, pop_pc[i], 32'(4 * i)); end
        checks++; if (pop_cyc[i] - t0 !== 2 + i) begin errors++; $display("FAIL stream_pop_cycle[%0d] got %0d exp %0d", i, pop_cyc[i] - t0, 2 + i); end
      end
      checks++; if (pop_instr[1] !== 32'h1000_0004) begin errors++; $display("FAIL stream_instr got %h exp 10000004", pop_instr[1]); end
    end
  endtask

  task automatic test_backpressure;
    start_run(1'b0, 1);
    cycles(10);
    checks++; if (req_log.size() !== 2) begin errors++; $display("FAIL bp_req_count got %0d exp 2", req_log.size()); end
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL bp_ir_valid got %b exp 1", ir_valid); end
    ir_ready = 1'b1;
    cycles(3);
    checks++; if (pop_pc.size() < 2) begin errors++; $display("FAIL bp_pop_count got %0d exp >=2", pop_pc.size()); end
    else begin
      checks++; if (pop_pc[0] !== 32'h0) begin errors++; $display("FAIL bp_pop0 got %h exp 00000000", pop_pc[0]); end
      checks++; if (pop_pc[1] !== 32'h4) begin errors++; $display("FAIL bp_pop1 got %h exp 00000004", pop_pc[1]); end
    end
  endtask

  task automatic test_redirect_drop;
    int bad;
    start_run(1'b1, 3);
    cycles(2);
    checks++; if (req_log.size() !== 2) begin errors++; $display("FAIL drop_outstanding got %0d exp 2", req_log.size()); end
    pulse_redirect(32'h100);
    for (int i = 0; i < 40 && pop_pc.size() < 3; i++) cycles(1);
    checks++; if (pop_pc.size() < 3) begin errors++; $display("FAIL drop_timeout got %0d pops exp >=3", pop_pc.size()); end
    else begin
      checks++; if (pop_pc[0] !== 32'h100) begin errors++; $display("FAIL drop_first_pc got %h exp 00000100", pop_pc[0]); end
      checks++; if (pop_instr[0] !== 32'h1000_0100) begin errors++; $display("FAIL drop_first_instr got %h exp 10000100", pop_instr[0]); end
      checks++; if (req_log[2].a !== 32'h100) begin errors++; $display("FAIL drop_next_req got %h exp 00000100", req_log[2].a); end
      bad = 0;
      foreach (pop_pc[i]) if (pop_pc[i] !== 32'h100 + 32'(4 * i)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL drop_sequence got %0d out-of-order pcs exp 0", bad); end
    end
  endtask

  task automatic test_redirect_collide;
    int n4;
    start_run(1'b1, 1);
    cycles(3);
    checks++; if ({imem_rsp_valid, ir_valid} !== 2'b11) begin errors++; $display("FAIL collide_setup got rsp=%b ir=%b exp 1 1", imem_rsp_valid, ir_valid); end
    checks++; if (ir_pc !== 32'h4) begin errors++; $display("FAIL collide_head got %h exp 00000004", ir_pc); end
    pulse_redirect(32'h200);
    cycles(6);
    n4 = 0;
    foreach (pop_pc[i]) if (pop_pc[i] == 32'h4 || pop_pc[i] == 32'h8) n4++;
    checks++; if (n4 !== 1) begin errors++; $display("FAIL collide_consumed_once got %0d exp 1", n4); end
    checks++; if (pop_pc.size() < 3) begin errors++; $display("FAIL collide_pop_count got %0d exp >=3", pop_pc.size()); end
    else begin
      checks++; if (pop_pc[2] !== 32'h200) begin errors++; $display("FAIL collide_target got %h exp 00000200", pop_pc[2]); end
    end
  endtask

  task automatic test_misaligned;
    int n;
    start_run(1'b1, 1);
    cycles(3);
    pulse_redirect(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    ir_ready = 1'b0;
    for (int i = 0; i < 20 && !ir_valid; i++) cycles(1);
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL fault_valid got %b exp 1", ir_valid); end
    checks++; if (ir_fault !== 1'b1) begin errors++; $display("FAIL fault_flag got %b exp 1", ir_fault); end
    checks++; if (ir_pc !== 32'h102) begin errors++; $display("FAIL fault_pc got %h exp 00000102", ir_pc); end
    checks++; if (ir_instr !== 32'h13) begin errors++; $display("FAIL fault_instr got %h exp 00000013", ir_instr); end
    n = req_log.size();
    cycles(10);
    checks++; if (req_log.size() !== n) begin errors++; $display("FAIL fault_no_req got %0d exp %0d", req_log.size(), n); end
    ir_ready = 1'b1;
    cycles(1);
    ir_ready = 1'b0;
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL fault_no_repeat got %b exp 0", ir_valid); end
    ir_ready = 1'b1;
    pop_pc.delete();
    pulse_redirect(32'h200);
    for (int i = 0; i < 20 && pop_pc.size() < 1; i++) cycles(1);
    checks++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h200) begin errors++; $display("FAIL fault_exit got %0d pops exp pc 00000200", pop_pc.size()); end
`else
    pop_pc.delete();
    pop_fault.delete();
    for (int i = 0; i < 20 && pop_pc.size() < 1; i++) cycles(1);
    checks++; if (pop_pc.size() < 1) begin errors++; $display("FAIL align_timeout got 0 pops exp 1"); end
    else begin
      checks++; if (pop_pc[0] !== 32'h100) begin errors++; $display("FAIL align_forced_pc got %h exp 00000100", pop_pc[0]); end
      checks++; if (pop_fault[0] !== 1'b0) begin errors++; $display("FAIL align_fault got %b exp 0", pop_fault[0]); end
    end
    n = 0;
`endif
  endtask

  task automatic test_wrap;
    start_run(1'b1, 1);
    cycles(2);
    pulse_redirect(32'hFFFF_FFF8);
    req_log.delete();
    cycles(5);
    checks++; if (req_log.size() < 3) begin errors++; $display("FAIL wrap_count got %0d exp >=3", req_log.size()); end
    else begin
      checks++; if (req_log[0].a !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_req0 got %h exp fffffff8", req_log[0].a); end
      checks++; if (req_log[1].a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req1 got %h exp fffffffc", req_log[1].a); end
      checks++; if (req_log[2].a !== 32'h0000_0000) begin errors++; $display("FAIL wrap_req2 got %h exp 00000000", req_log[2].a); end
    end
    #1;
    reset = 1'b0;
    #1;
    checks++; if ({imem_req_valid, ir_valid} !== 2'b00) begin errors++; $display("FAIL async_reset_valid got req=%b ir=%b exp 0 0", imem_req_valid, ir_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL async_reset_addr got %h exp 00000000", imem_req_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collide();
    test_misaligned();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multi-cycle RV32 core. Sits directly upstream of the instruction register and decoder. It issues word reads to instruction memory through a valid/ready request channel, buffers in-order responses in a small prefetch FIFO, and presents `{pc, instr}` pairs to the core on a valid/ready channel. Taken branches, JAL and JALR redirect the fetch PC; every buffered or in-flight stale fetch is discarded.

## Interface
Parameters:
- `XLEN`, 32 — address/data width.
- `RESET_PC`, 32'h0000_0000 — first fetch address after reset.
- `FIFO_DEPTH`, 2 — prefetch entries; also the maximum number of outstanding requests. Legal values: 2 or 4.

Ports. One clock; reset is asynchronous and active-low (`reset` = 0 asserts).
- `clk`  in  1  — core clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `imem_req_valid`  out  1  — fetch request valid.
- `imem_req_ready`  in  1  — memory accepts the request.
- `imem_req_addr`  out  XLEN  — word-aligned fetch address.
- `imem_rsp_valid`  in  1  — response data valid. Responses return in order; there is no backpressure.
- `imem_rsp_data`  in  32  — instruction word.
- `redirect_valid`  in  1  — one-cycle pulse from the write-back stage for a non-sequential `pc_next`.
- `redirect_pc`  in  XLEN  — new fetch target.
- `ir_valid`  out  1  — FIFO head valid.
- `ir_ready`  in  1  — core takes the head; asserted in FETCH state.
- `ir_instr`  out  32  — head instruction.
- `ir_pc`  out  XLEN  — address of the head instruction.
- `ir_fault`  out  1  — head is an instruction-address-misaligned fault.

## Operation
- Registers:
  - `fetch_pc`.
  - `out_cnt`, outstanding requests, range 0..FIFO_DEPTH.
  - `drop_cnt`, stale responses still to discard.
  - FIFO of `{pc, instr, fault}`.
  - 2-bit state.
- Credit rule: `imem_req_valid = (state==RUN) && drop_cnt==0 && (out_cnt + fifo_count) < FIFO_DEPTH && !redirect_valid`. This guarantees every response has FIFO space.
- On `imem_req_valid && imem_req_ready`:
  - `imem_req_addr` = `fetch_pc`.
  - `fetch_pc += 4` (modulo 2^XLEN; wraps from 0xFFFF_FFFC to 0).
  - `out_cnt++`.
- On `imem_rsp_valid`:
  - `out_cnt--`.
  - If `drop_cnt>0`: decrement `drop_cnt` and discard the data.
  - Otherwise push `{pc_of_response, imem_rsp_data, 0}`. `pc_of_response` is tracked with a response-PC register that increments by 4 per kept response.
- States:
  - RUN — normal fetch.
  - DRAIN — `drop_cnt>0`; no requests issued. Go to RUN, or to FAULT if a fault is pending, when `drop_cnt` reaches 0.
  - FAULT — no requests issued; head holds the fault entry. Leave only on `redirect_valid`.
- Redirect (any state):
  - FIFO flushed. A pop in the same cycle completes first, then the flush.
  - `drop_cnt <= out_cnt` minus the response arriving this cycle.
  - `fetch_pc` and response-PC load `redirect_pc`.
  - Next state: DRAIN if `drop_cnt` becomes nonzero, else RUN.
- A response arriving in the redirect cycle is discarded.
- Simultaneous push and pop: both take effect.
- Reset asserted mid-operation: all state clears immediately. Responses that arrive later for pre-reset requests are the memory's responsibility; the memory is reset on the same net.

## Timing
- Reset values:
  - `imem_req_valid`=0 while `reset`=0.
  - `imem_req_addr`=RESET_PC.
  - `ir_valid`=0, `ir_instr`=32'h0000_0013, `ir_pc`=RESET_PC, `ir_fault`=0.
  - Counters 0, state RUN.
- First request is valid in the first cycle after reset deasserts.
- Latency: request accepted in cycle N, response in N+k, `ir_valid` in N+k+1 (FIFO output is registered).
- After a redirect in cycle R with no stale fetches, the first request for `redirect_pc` is issued in R+1.
- Throughput: one instruction per cycle sustained when k=1 and `ir_ready` is held high.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - `redirect_pc[1:0]!=0` sets a pending fault.
  - After drain, a single entry `{redirect_pc, 32'h0000_0013, 1}` is pushed and the block enters FAULT.
  - The fault entry is not popped-and-repeated: after a pop, `ir_valid`=0 until the next redirect.
- Undefined:
  - `redirect_pc[1:0]` is forced to 0.
  - `ir_fault` is tied 0.
  - FAULT state is unreachable.

## Structure
- Shared package `fetch_pkg`:
  - state encoding (RUN, DRAIN, FAULT).
  - `NOP_INSTR` = 32'h0000_0013.
  - entry struct `{pc, instr, fault}`.
- Sub-module `fetch_fifo`: parameterised depth, registered head, synchronous flush, push/pop/count. `fetch_unit` holds the FSM, counters and PC logic.

## Test plan
- Reset release, memory k=1, `ir_ready`=1 → requests 0x0, 0x4, 0x8 on consecutive cycles; `ir_valid` first at cycle 3 with `ir_pc`=0x0.
- `ir_ready`=0 for 10 cycles → exactly FIFO_DEPTH requests issued and no more; release → entries 0x0, 0x4 in order.
- Two requests outstanding, memory k=3, redirect to 0x100 → both old responses dropped; next `ir_pc`=0x100 and no stale PC reaches `ir_valid`.
- Redirect in the same cycle as a response and a pop → popped entry is consumed once; the response is discarded; `ir_pc`=redirect target next.
- With macro: redirect to 0x102 → `ir_valid`=1, `ir_fault`=1, `ir_pc`=0x102, `ir_instr`=0x13; no requests until a redirect to 0x200. Without macro: fetch goes to 0x100.
- `fetch_pc`=0xFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
